// File: rtl/turf_trigger_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : turf_trigger_dispatcher
// Description : Upstream feeder of the SURF serial command interface.
//               Accepts trigger pulses and tags each one with a 32-bit event ID
//               and the next SURF digitizer buffer in strict round-robin order.
//               Accepted triggers are queued, and one start per event is issued
//               to the command interface. Buffer occupancy is tracked until
//               readout releases each buffer. A trigger that finds its buffer
//               still occupied is dropped and counted.
// Options     : DISPATCH_TIMEOUT_EN - adds a SEND-state watchdog that sets the
//               sticky timeout_o flag and forces the FSM on to GAP.
// Revision    : 1.0 - initial release
// ============================================================================
module turf_trigger_dispatcher #(
  parameter int NUM_BUFFERS = 4,   // fixed at 4 to match the 2-bit buffer field
  parameter int GAP_CYCLES  = 2,   // idle cycles between done and next start (1..15)
  parameter int TIMEOUT     = 63   // watchdog limit in cycles (DISPATCH_TIMEOUT_EN only)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        trig_i,
  input  logic        clear_i,
  input  logic [1:0]  clear_buf_i,
  input  logic        busy_i,
  input  logic        done_i,
  output logic        start_o,
  output logic [31:0] event_id_o,
  output logic [1:0]  buffer_o,
  output logic [3:0]  buf_busy_o,
  output logic [15:0] drop_cnt_o,
  output logic        timeout_o
);

  localparam int              QDEPTH     = NUM_BUFFERS;
  localparam logic [3:0]      c_GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [NUM_BUFFERS-1:0] c_ONE = {{(NUM_BUFFERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Allocation state
  // --------------------------------------------------------------------------
  logic [NUM_BUFFERS-1:0] buf_busy_q, buf_busy_d;
  logic [1:0]             ptr_q;
  logic [31:0]            event_ctr_q;
  logic [15:0]            drop_cnt_q;

  logic [NUM_BUFFERS-1:0] w_clear_mask;
  logic [NUM_BUFFERS-1:0] w_busy_cleared;
  logic                   w_trig_accept;
  logic                   w_trig_drop;

  // --------------------------------------------------------------------------
  // Event queue: {event_id[31:0], buffer[1:0]}
  // --------------------------------------------------------------------------
  logic [33:0] fifo_q [QDEPTH];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        w_pop;

  // --------------------------------------------------------------------------
  // Dispatch FSM and command outputs
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        busy_prev_q;
  logic [31:0] event_id_q, event_id_d;
  logic [1:0]  buffer_q, buffer_d;

`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
`else
  logic [7:0]  w_timeout_unused;
  assign w_timeout_unused = 8'(TIMEOUT);
`endif

  // Clear is applied before the trigger looks at the pointed-to buffer, so a
  // same-cycle release of that buffer lets the trigger through.
  always_comb begin
    w_clear_mask   = clear_i ? (c_ONE << clear_buf_i) : '0;
    w_busy_cleared = buf_busy_q & ~w_clear_mask;
    w_trig_accept  = trig_i & ~w_busy_cleared[ptr_q];
    w_trig_drop    = trig_i &  w_busy_cleared[ptr_q];
    buf_busy_d     = w_busy_cleared | (w_trig_accept ? (c_ONE << ptr_q) : '0);
  end

  // Allocation registers; counters advance only on an accepted trigger.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_busy_q  <= '0;
      ptr_q       <= '0;
      event_ctr_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      buf_busy_q <= buf_busy_d;
      if (w_trig_accept) begin
        event_ctr_q <= event_ctr_q + 32'd1;
        ptr_q       <= ptr_q + 2'd1;
      end
      if (w_trig_drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // Occupancy bounds the queue: every entry owns an allocated buffer, so a
  // push never meets a full queue.
  always_comb begin
    count_d = count_q + {2'b00, w_trig_accept} - {2'b00, w_pop};
  end

  // Queue storage and pointers; simultaneous push and pop both take effect.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_trig_accept) begin
        fifo_q[wr_ptr_q] <= {event_ctr_q, ptr_q};
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
    end
  end

  // Next-state and output decode for the dispatch FSM.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = '0;
    w_pop      = 1'b0;
    start_o    = 1'b0;
    event_id_d = event_id_q;
    buffer_d   = buffer_q;
`ifdef DISPATCH_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((count_q != 3'd0) && !busy_i) begin
          w_pop      = 1'b1;
          event_id_d = fifo_q[rd_ptr_q][33:2];
          buffer_d   = fifo_q[rd_ptr_q][1:0];
          state_d    = ST_START;
        end
      end
      ST_START: begin
        start_o = 1'b1;
        state_d = ST_SEND;
`ifdef DISPATCH_TIMEOUT_EN
        // START counts as the first watchdog cycle.
        tmo_cnt_d = 8'd1;
`endif
      end
      ST_SEND: begin
        // Completion is either an explicit done or a falling edge of busy.
        if (done_i || (busy_prev_q && !busy_i)) begin
          state_d = ST_GAP;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_GAP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      ST_GAP: begin
        if (gap_cnt_q == c_GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, gap counter, busy history and held command fields.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      busy_prev_q <= 1'b0;
      event_id_q  <= '0;
      buffer_q    <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_prev_q <= busy_i;
      event_id_q  <= event_id_d;
      buffer_q    <= buffer_d;
`ifdef DISPATCH_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign event_id_o = event_id_q;
  assign buffer_o   = buffer_q;
  assign buf_busy_o = buf_busy_q;
  assign drop_cnt_o = drop_cnt_q;
`ifdef DISPATCH_TIMEOUT_EN
  assign timeout_o  = timeout_q;
`else
  assign timeout_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_turf_trigger_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_turf_trigger_dispatcher
// Description : Self-checking bench for turf_trigger_dispatcher. A reference
//               allocation model pushes expected {event_id, buffer} pairs into
//               a scoreboard queue; a monitor pops and compares on each start.
//               A responder process emulates the command interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turf_trigger_dispatcher;

  localparam int GAP = 2;
  localparam int TMO = 63;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        trig_i;
  logic        clear_i;
  logic [1:0]  clear_buf_i;
  logic        busy_i;
  logic        done_i;
  logic        start_o;
  logic [31:0] event_id_o;
  logic [1:0]  buffer_o;
  logic [3:0]  buf_busy_o;
  logic [15:0] drop_cnt_o;
  logic        timeout_o;

  turf_trigger_dispatcher #(
    .NUM_BUFFERS (4),
    .GAP_CYCLES  (GAP),
    .TIMEOUT     (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .trig_i      (trig_i),
    .clear_i     (clear_i),
    .clear_buf_i (clear_buf_i),
    .busy_i      (busy_i),
    .done_i      (done_i),
    .start_o     (start_o),
    .event_id_o  (event_id_o),
    .buffer_o    (buffer_o),
    .buf_busy_o  (buf_busy_o),
    .drop_cnt_o  (drop_cnt_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model of the allocator and the scoreboard
  logic [33:0] sb_q[$];
  logic [3:0]  m_busy;
  logic [1:0]  m_ptr;
  logic [31:0] m_ctr;
  logic [15:0] m_drop;
  logic [33:0] mon_exp;

  int resp_busy     = 36;
  int last_done     = 0;
  bit have_done     = 1'b0;
  int last_start    = 0;
  int start_count   = 0;
  int exp_start_cyc = -1;

  task automatic model_clear();
    m_busy = '0; m_ptr = '0; m_ctr = '0; m_drop = '0;
    sb_q.delete();
    have_done = 1'b0;
    exp_start_cyc = -1;
  endtask

  task automatic model_step(input logic t, input logic c, input logic [1:0] cb);
    if (c) m_busy[cb] = 1'b0;
    if (t) begin
      if (!m_busy[m_ptr]) begin
        m_busy[m_ptr] = 1'b1;
        sb_q.push_back({m_ctr, m_ptr});
        m_ctr = m_ctr + 32'd1;
        m_ptr = m_ptr + 2'd1;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end
  endtask

  // Drive one cycle of trigger/clear starting at the current falling edge.
  task automatic pulse(input logic t, input logic c, input logic [1:0] cb);
    trig_i = t; clear_i = c; clear_buf_i = cb;
    model_step(t, c, cb);
    @(negedge clk);
    trig_i = 1'b0; clear_i = 1'b0; clear_buf_i = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n_i = 1'b0;
    trig_i = 1'b0; clear_i = 1'b0; clear_buf_i = 2'd0;
    repeat (3) @(negedge clk);
    model_clear();
    rst_n_i = 1'b1;
    @(negedge clk);
  endtask

  // Wait until the scoreboard is empty and the interface has been quiet.
  task automatic wait_drain(input int limit);
    int n = 0;
    int quiet = 0;
    while (n < limit && quiet < 8) begin
      @(negedge clk);
      n++;
      if (sb_q.size() == 0 && !busy_i && !done_i && !start_o) quiet++;
      else quiet = 0;
    end
    if (quiet < 8) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: pending=%0d after %0d cycles, required 0", sb_q.size(), n);
    end
  endtask

  task automatic wait_start(input int s0, input int limit);
    int n = 0;
    while (start_count == s0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (start_count == s0) begin
      vectors++; miscompares++;
      $display("FAIL start_timeout: starts=%0d, required %0d", start_count, s0 + 1);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    trig_i = 1'b0; clear_i = 1'b0; clear_buf_i = 2'd0;
    busy_i = 1'b0; done_i = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    vectors++; if (start_o !== 1'b0) begin miscompares++; $display("FAIL rst_start: got %b required 0", start_o); end
    vectors++; if (event_id_o !== 32'd0) begin miscompares++; $display("FAIL rst_event_id: got %h required 0", event_id_o); end
    vectors++; if (buffer_o !== 2'd0) begin miscompares++; $display("FAIL rst_buffer: got %0d required 0", buffer_o); end
    vectors++; if (buf_busy_o !== 4'b0000) begin miscompares++; $display("FAIL rst_buf_busy: got %b required 0000", buf_busy_o); end
    vectors++; if (drop_cnt_o !== 16'd0) begin miscompares++; $display("FAIL rst_drop: got %0d required 0", drop_cnt_o); end
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL rst_timeout: got %b required 0", timeout_o); end
    rst_n_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int s0;
    s0 = start_count;
    exp_start_cyc = cyc + 2;
    pulse(1'b1, 1'b0, 2'd0);
    wait_drain(500);
    vectors++; if (start_count !== s0 + 1) begin miscompares++; $display("FAIL single_starts: got %0d required %0d", start_count - s0, 1); end
    vectors++; if (buf_busy_o !== 4'b0001) begin miscompares++; $display("FAIL single_buf_busy: got %b required 0001", buf_busy_o); end
  endtask

  task automatic test_burst();
    int s0;
    do_reset();
    s0 = start_count;
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 2'd0);
    wait_drain(1000);
    vectors++; if (start_count !== s0 + 4) begin miscompares++; $display("FAIL burst_starts: got %0d required 4", start_count - s0); end
    vectors++; if (buf_busy_o !== 4'b1111) begin miscompares++; $display("FAIL burst_buf_busy: got %b required 1111", buf_busy_o); end
    vectors++; if (drop_cnt_o !== 16'd0) begin miscompares++; $display("FAIL burst_drop: got %0d required 0", drop_cnt_o); end
  endtask

  task automatic test_full();
    pulse(1'b1, 1'b0, 2'd0);
    pulse(1'b1, 1'b0, 2'd0);
    vectors++; if (drop_cnt_o !== 16'd2) begin miscompares++; $display("FAIL full_drop: got %0d required 2", drop_cnt_o); end
    vectors++; if (buf_busy_o !== 4'b1111) begin miscompares++; $display("FAIL full_buf_busy: got %b required 1111", buf_busy_o); end
  endtask

  task automatic test_simultaneous();
    int s0;
    s0 = start_count;
    pulse(1'b1, 1'b1, 2'd0);
    vectors++; if (buf_busy_o !== 4'b1111) begin miscompares++; $display("FAIL simul_buf_busy: got %b required 1111", buf_busy_o); end
    wait_drain(500);
    vectors++; if (start_count !== s0 + 1) begin miscompares++; $display("FAIL simul_starts: got %0d required 1", start_count - s0); end
    vectors++; if (drop_cnt_o !== 16'd2) begin miscompares++; $display("FAIL simul_drop: got %0d required 2", drop_cnt_o); end
    // Releasing an already-free buffer changes nothing.
    pulse(1'b0, 1'b1, 2'd2);
    pulse(1'b0, 1'b1, 2'd2);
    vectors++; if (buf_busy_o !== 4'b1011) begin miscompares++; $display("FAIL clear_free: got %b required 1011", buf_busy_o); end
  endtask

  task automatic test_wrap();
    int s0;
    do_reset();
    dut.event_ctr_q = 32'hFFFF_FFFF;
    m_ctr = 32'hFFFF_FFFF;
    s0 = start_count;
    pulse(1'b1, 1'b0, 2'd0);
    pulse(1'b1, 1'b0, 2'd0);
    wait_drain(1000);
    vectors++; if (start_count !== s0 + 2) begin miscompares++; $display("FAIL wrap_starts: got %0d required 2", start_count - s0); end
  endtask

  task automatic test_reset_mid_send();
    int s0;
    do_reset();
    resp_busy = 200;
    s0 = start_count;
    pulse(1'b1, 1'b0, 2'd0);
    wait_start(s0, 20);
    repeat (5) @(negedge clk);
    #2 rst_n_i = 1'b0;
    #1;
    vectors++; if (start_o !== 1'b0) begin miscompares++; $display("FAIL midrst_start: got %b required 0", start_o); end
    vectors++; if (buf_busy_o !== 4'b0000) begin miscompares++; $display("FAIL midrst_buf_busy: got %b required 0000", buf_busy_o); end
    repeat (3) @(negedge clk);
    model_clear();
    rst_n_i = 1'b1;
    s0 = start_count;
    repeat (30) @(negedge clk);
    vectors++; if (start_count !== s0) begin miscompares++; $display("FAIL midrst_no_start: got %0d starts required 0", start_count - s0); end
    resp_busy = 36;
  endtask

  task automatic test_timeout();
    int s0;
    int s_cyc;
    do_reset();
    resp_busy = 100;
    s0 = start_count;
    pulse(1'b1, 1'b0, 2'd0);
    wait_start(s0, 20);
    s_cyc = last_start;
`ifdef DISPATCH_TIMEOUT_EN
    while (cyc < s_cyc + TMO - 1) @(negedge clk);
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL timeout_early: got %b required 0", timeout_o); end
    @(negedge clk);
    vectors++; if (timeout_o !== 1'b1) begin miscompares++; $display("FAIL timeout_set: got %b required 1", timeout_o); end
    wait_drain(500);
    vectors++; if (timeout_o !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b required 1", timeout_o); end
`else
    while (cyc < s_cyc + TMO + 5) @(negedge clk);
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL timeout_tied: got %b required 0", timeout_o); end
    wait_drain(500);
`endif
    resp_busy = 36;
  endtask

  initial begin
    rst_n_i = 1'b0;
    trig_i = 1'b0; clear_i = 1'b0; clear_buf_i = 2'd0;
    busy_i = 1'b0; done_i = 1'b0;
    model_clear();

    fork
      // Command-interface responder
      forever begin
        @(negedge clk);
        if (rst_n_i && start_o) begin
          busy_i = 1'b1;
          for (int k = 0; k < resp_busy && rst_n_i; k++) @(negedge clk);
          if (rst_n_i) begin
            busy_i = 1'b0;
            done_i = 1'b1;
            last_done = cyc;
            have_done = 1'b1;
            @(negedge clk);
            done_i = 1'b0;
          end else begin
            busy_i = 1'b0;
          end
        end
      end
      // Scoreboard monitor
      forever begin
        @(negedge clk);
        if (rst_n_i && start_o) begin
          start_count++;
          last_start = cyc;
          vectors++;
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL start_unexpected: got start id=%h buf=%0d, required no start", event_id_o, buffer_o);
          end else begin
            mon_exp = sb_q.pop_front();
            if ({event_id_o, buffer_o} !== mon_exp) begin
              miscompares++;
              $display("FAIL start_data: got id=%h buf=%0d, required id=%h buf=%0d",
                       event_id_o, buffer_o, mon_exp[33:2], mon_exp[1:0]);
            end
          end
          if (have_done) begin
            vectors++;
            if (cyc < last_done + 1 + GAP) begin
              miscompares++;
              $display("FAIL gap_spacing: got start at %0d, required >= %0d", cyc, last_done + 1 + GAP);
            end
          end
          if (exp_start_cyc >= 0) begin
            vectors++;
            if (cyc != exp_start_cyc) begin
              miscompares++;
              $display("FAIL start_latency: got cycle %0d, required %0d", cyc, exp_start_cyc);
            end
            exp_start_cyc = -1;
          end
        end
      end
      begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
      end
    join_none

    test_reset();
    test_single();
    test_burst();
    test_full();
    test_simultaneous();
    test_wrap();
    test_reset_mid_send();
    test_timeout();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
